// File: rtl/drlp_pkg.sv
// drlp_pkg: drain FSM state encoding and default datapath widths shared with the PE
package drlp_pkg;
   localparam int PDATA_W = 16;
   localparam int PMEM_AW = 8;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_t;
endpackage

// File: rtl/drlp_skid_fifo.sv
// drlp_skid_fifo: two-entry registered first-word-first-out buffer with occupancy
module drlp_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       occ
);
   logic [WIDTH-1:0] mem [2];
   logic wr_ptr, rd_ptr, do_push, do_pop;
   assign do_pop = pop && occ != 2'd0;
   assign do_push = push && (occ != 2'd2 || do_pop);
   assign data_out = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ <= 2'd0;
      end else begin
         if (do_push) mem[wr_ptr] <= data_in;
         wr_ptr <= wr_ptr ^ do_push;
         rd_ptr <= rd_ptr ^ do_pop;
         occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/drlp_psum_drain.sv
// drlp_psum_drain: walks a pmem address range, packs both bank lanes (optional ReLU) onto a valid/ready stream
module drlp_psum_drain
   import drlp_pkg::*;
#(
   parameter int PDATA_WIDTH     = PDATA_W,
   parameter int PMEM_ADDR_WIDTH = PMEM_AW,
   parameter int OUT_WIDTH       = 2*PDATA_WIDTH
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [PMEM_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [PMEM_ADDR_WIDTH:0]   i_len,
   input  logic                       i_relu,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_pmem_rd_en0,
   output logic                       o_pmem_rd_en1,
   output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr0,
   output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr1,
   input  logic [PDATA_WIDTH-1:0]     i_result0,
   input  logic [PDATA_WIDTH-1:0]     i_result1,
   output logic [OUT_WIDTH-1:0]       o_data,
   output logic                       o_valid,
   input  logic                       i_ready
);
   drain_state_t state, state_n;
   logic [PMEM_ADDR_WIDTH-1:0] addr;
   logic [PMEM_ADDR_WIDTH:0] remaining;
   logic relu, infl, issue, pop, accept, last;
   logic [1:0] occ;
   logic [2:0] load;
   logic [PDATA_WIDTH-1:0] lane0, lane1;
   logic [OUT_WIDTH-1:0] packed_word;
   assign o_busy = state == RUN || state == FLUSH;
   assign o_done = state == DONE;
   assign accept = i_start && !o_busy;
   assign o_valid = occ != 2'd0;
   assign pop = o_valid && i_ready;
   // a pop this cycle frees a slot, so credit may be spent in the same cycle
   assign load = {1'b0, occ} + {2'b0, infl};
   assign issue = state == RUN && load < (pop ? 3'd3 : 3'd2);
   assign last = remaining == {{PMEM_ADDR_WIDTH{1'b0}}, 1'b1};
   assign o_pmem_rd_en0 = issue;
   assign o_pmem_rd_en1 = issue;
   assign o_pmem_rd_addr0 = addr;
   assign o_pmem_rd_addr1 = addr;
   assign lane0 = relu && i_result0[PDATA_WIDTH-1] ? '0 : i_result0;
   assign lane1 = relu && i_result1[PDATA_WIDTH-1] ? '0 : i_result1;
   assign packed_word = {lane1, lane0};
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: state_n = accept ? (i_len != '0 ? RUN : DONE) : IDLE;
         RUN:        state_n = issue && last ? FLUSH : RUN;
         FLUSH:      state_n = !infl && (occ == 2'd0 || (occ == 2'd1 && pop)) ? DONE : FLUSH;
         default:    state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr <= '0;
         remaining <= '0;
         relu <= 1'b0;
         infl <= 1'b0;
      end else begin
         infl <= issue;
         if (accept) begin
            addr <= i_base_addr;
            remaining <= i_len;
            relu <= i_relu;
         end else if (issue) begin
            addr <= addr + PMEM_ADDR_WIDTH'(1);
            remaining <= remaining - (PMEM_ADDR_WIDTH+1)'(1);
         end
      end
   end
   drlp_skid_fifo #(.WIDTH(OUT_WIDTH)) u_fifo (
      .clk(i_clk),
      .rst(i_rst),
      .push(infl),
      .data_in(packed_word),
      .pop(pop),
      .data_out(o_data),
      .occ(occ)
   );
endmodule

// File: tb/tb_drlp_psum_drain.sv
// tb_drlp_psum_drain: directed vector and sequence checks of the psum drain engine
module tb_drlp_psum_drain;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic i_start = 1'b0;
   logic [7:0] i_base_addr = '0;
   logic [8:0] i_len = '0;
   logic i_relu = 1'b0;
   logic i_ready = 1'b1;
   logic [15:0] i_result0 = '0;
   logic [15:0] i_result1 = '0;
   logic o_busy, o_done, o_pmem_rd_en0, o_pmem_rd_en1, o_valid;
   logic [7:0] o_pmem_rd_addr0, o_pmem_rd_addr1;
   logic [31:0] o_data;
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic [7:0] rd_q [$];
   logic [31:0] got [$];
   int done_cnt = 0;
   bit prev_stall = 0;
   logic [31:0] prev_data = '0;
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] v0;
      logic [15:0] v1;
      logic        relu;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [6];

   always #5 i_clk = ~i_clk;

   drlp_psum_drain dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_len(i_len), .i_relu(i_relu), .o_busy(o_busy), .o_done(o_done),
      .o_pmem_rd_en0(o_pmem_rd_en0), .o_pmem_rd_en1(o_pmem_rd_en1),
      .o_pmem_rd_addr0(o_pmem_rd_addr0), .o_pmem_rd_addr1(o_pmem_rd_addr1),
      .i_result0(i_result0), .i_result1(i_result1), .o_data(o_data),
      .o_valid(o_valid), .i_ready(i_ready)
   );

   // pmem banks: one-cycle read latency, junk on the bus when not enabled
   always @(posedge i_clk) begin
      i_result0 <= o_pmem_rd_en0 ? mem0[o_pmem_rd_addr0] : 16'hBAD0;
      i_result1 <= o_pmem_rd_en1 ? mem1[o_pmem_rd_addr1] : 16'hBAD1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic clear_log();
      rd_q.delete();
      got.delete();
      done_cnt = 0;
   endtask

   function automatic logic [31:0] exp_word(input logic [7:0] a, input logic r);
      logic [15:0] l0, l1;
      l0 = mem0[a];
      l1 = mem1[a];
      if (r && $signed(l0) < 0) l0 = '0;
      if (r && $signed(l1) < 0) l1 = '0;
      return {l1, l0};
   endfunction

   always @(negedge i_clk) begin
      #2;
      if (i_rst) begin
         clear_log();
         prev_stall = 0;
      end else begin
         if (o_pmem_rd_en0 || o_pmem_rd_en1) begin
            chk("rd_en_pair", {31'b0, o_pmem_rd_en1}, {31'b0, o_pmem_rd_en0});
            chk("rd_addr_pair", {24'b0, o_pmem_rd_addr1}, {24'b0, o_pmem_rd_addr0});
            rd_q.push_back(o_pmem_rd_addr0);
         end
         if (prev_stall) begin
            chk("stall_valid", {31'b0, o_valid}, 32'd1);
            chk("stall_data", o_data, prev_data);
         end
         if (o_valid && i_ready) got.push_back(o_data);
         if (o_done) done_cnt++;
         if (o_pmem_rd_en0 || (o_valid && i_ready))
            chk("outstanding_le2", {31'b0, (rd_q.size() - got.size()) <= 2}, 32'd1);
         prev_stall = o_valid && !i_ready;
         prev_data = o_data;
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, o_done}, 32'd0);
      chk({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
      chk({tag, "_rd_en0"}, {31'b0, o_pmem_rd_en0}, 32'd0);
      chk({tag, "_rd_en1"}, {31'b0, o_pmem_rd_en1}, 32'd0);
      chk({tag, "_rd_addr0"}, {24'b0, o_pmem_rd_addr0}, 32'd0);
      chk({tag, "_rd_addr1"}, {24'b0, o_pmem_rd_addr1}, 32'd0);
      chk({tag, "_data"}, o_data, 32'd0);
   endtask

   task automatic run_drain(input logic [7:0] base, input logic [8:0] len, input logic relu, input bit rnd);
      #3;
      clear_log();
      tick();
      i_start = 1'b1; i_base_addr = base; i_len = len; i_relu = relu; i_ready = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 300 && !o_done; k++) begin
         i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      chk("drain_done", {31'b0, o_done}, 32'd1);
      i_ready = 1'b1;
      #3;
      chk("done_once", done_cnt, 32'd1);
   endtask

   task automatic check_words(input logic [7:0] base, input int len, input logic relu);
      logic [7:0] a;
      chk("word_count", got.size(), len);
      chk("rd_count", rd_q.size(), len);
      for (int i = 0; i < len && i < got.size(); i++) begin
         a = base + 8'(i);
         chk("word", got[i], exp_word(a, relu));
      end
      for (int i = 0; i < len && i < rd_q.size(); i++) begin
         a = base + 8'(i);
         chk("rd_addr_seq", {24'b0, rd_q[i]}, {24'b0, a});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem0[a] = 16'h1000 + 16'(a);
         mem1[a] = 16'h2000 + 16'(a);
      end
      for (int i = 0; i < 4; i++) begin
         mem0[8'h10 + i] = 16'(i);
         mem1[8'h10 + i] = 16'(-i);
      end
      vt[0] = '{8'h40, 16'hFFFB, 16'h0007, 1'b1, 32'h0007_0000};
      vt[1] = '{8'h40, 16'hFFFB, 16'h0007, 1'b0, 32'h0007_FFFB};
      vt[2] = '{8'h41, 16'h0007, 16'hFFFB, 1'b1, 32'h0000_0007};
      vt[3] = '{8'h42, 16'h8000, 16'h7FFF, 1'b1, 32'h7FFF_0000};
      vt[4] = '{8'h43, 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000};
      vt[5] = '{8'h44, 16'h1234, 16'h8001, 1'b0, 32'h8001_1234};

      repeat (3) tick();
      i_rst = 1'b0;
      #1;
      check_idle_outputs("reset");

      // basic drain, cycle-exact
      #3;
      clear_log();
      tick();
      i_start = 1'b1; i_base_addr = 8'h10; i_len = 9'd4; i_relu = 1'b0; i_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         i_start = 1'b0;
         #1;
         chk($sformatf("basic_busy_c%0d", c), {31'b0, o_busy}, {31'b0, c <= 6});
         chk($sformatf("basic_rd_en_c%0d", c), {31'b0, o_pmem_rd_en0}, {31'b0, c <= 4});
         chk($sformatf("basic_valid_c%0d", c), {31'b0, o_valid}, {31'b0, c >= 3 && c <= 6});
         chk($sformatf("basic_done_c%0d", c), {31'b0, o_done}, {31'b0, c == 7});
         if (c <= 4) chk($sformatf("basic_addr_c%0d", c), {24'b0, o_pmem_rd_addr0}, 32'h10 + 32'(c - 1));
         if (c >= 3 && c <= 6) chk($sformatf("basic_data_c%0d", c), o_data, {16'(-(c - 3)), 16'(c - 3)});
      end
      #2;
      check_words(8'h10, 4, 1'b0);

      // address wrap
      run_drain(8'hFE, 9'd4, 1'b0, 1'b0);
      check_words(8'hFE, 4, 1'b0);

      // per-lane ReLU vectors
      for (int i = 0; i < 6; i++) begin
         mem0[vt[i].addr] = vt[i].v0;
         mem1[vt[i].addr] = vt[i].v1;
         run_drain(vt[i].addr, 9'd1, vt[i].relu, 1'b0);
         chk($sformatf("relu_vec%0d", i), got.size() > 0 ? got[0] : ~vt[i].exp, vt[i].exp);
      end

      // random backpressure
      run_drain(8'h80, 9'd8, 1'b0, 1'b1);
      check_words(8'h80, 8, 1'b0);

      // len=0, start accepted in DONE, start ignored while busy
      #3;
      clear_log();
      tick();
      i_start = 1'b1; i_base_addr = 8'h33; i_len = 9'd0; i_relu = 1'b0; i_ready = 1'b1;
      tick();
      #1;
      chk("len0_done_c1", {31'b0, o_done}, 32'd1);
      chk("len0_rd_en_c1", {31'b0, o_pmem_rd_en0}, 32'd0);
      chk("len0_busy_c1", {31'b0, o_busy}, 32'd0);
      i_base_addr = 8'h20; i_len = 9'd2;
      tick();
      i_start = 1'b0;
      #1;
      chk("done_start_busy", {31'b0, o_busy}, 32'd1);
      chk("done_start_rd_en", {31'b0, o_pmem_rd_en0}, 32'd1);
      chk("done_start_addr", {24'b0, o_pmem_rd_addr0}, 32'h20);
      tick();
      i_start = 1'b1; i_base_addr = 8'h50; i_len = 9'd5;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 50 && !o_done; k++) tick();
      chk("busy_start_done", {31'b0, o_done}, 32'd1);
      #3;
      check_words(8'h20, 2, 1'b0);
      chk("busy_start_done_cnt", done_cnt, 32'd2);
      repeat (10) tick();
      #3;
      chk("no_extra_words", got.size(), 32'd2);
      chk("no_extra_reads", rd_q.size(), 32'd2);
      chk("no_extra_done", done_cnt, 32'd2);

      // reset in cycle 4 of a len=8 drain
      clear_log();
      tick();
      i_start = 1'b1; i_base_addr = 8'h60; i_len = 9'd8; i_relu = 1'b0; i_ready = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (2) tick();
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      #1;
      check_idle_outputs("midrst");
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         chk("midrst_no_done", {31'b0, o_done}, 32'd0);
         chk("midrst_no_valid", {31'b0, o_valid}, 32'd0);
      end
      run_drain(8'h70, 9'd2, 1'b0, 1'b0);
      check_words(8'h70, 2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
